// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, constants and state encoding for the IF fetch stage
package if_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam int ExceptBus   = 32;

    // Reset asserts when rst equals this value.
    localparam logic RstEnable = 1'b0;

    // Values of a stall bit.
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Instruction-fetch address error (misaligned PC).
    localparam int EXC_IF_ADEL = 13;
    localparam logic [ExceptBus-1:0] EXC_IF_ADEL_MASK = 32'h1 << EXC_IF_ADEL;

    typedef enum logic [1:0] {
        IF_FETCH   = 2'd0,
        IF_VALID   = 2'd1,
        IF_DISCARD = 2'd2
    } if_state_t;

    function automatic logic word_aligned(input logic [InstAddrBus-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/if_branch_latch.sv
// rtl/if_branch_latch.sv - remembers a branch redirect until the PC can advance
//
// Ports:
//   clk, rst       clock and synchronous active-low reset
//   flush          exception redirect; cancels any remembered branch
//   advance        PC is stepping this cycle; the remembered branch is consumed
//   branch_flag    one-cycle branch pulse from ID
//   branch_target  destination accompanying branch_flag
//   pc             current PC
//   next_pc        PC to load on an advancing edge
module if_branch_latch
    import if_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   advance,
    input  logic                   branch_flag,
    input  logic [InstAddrBus-1:0] branch_target,
    input  logic [InstAddrBus-1:0] pc,
    output logic [InstAddrBus-1:0] next_pc
);

    logic                   pend_br;
    logic [InstAddrBus-1:0] br_tgt;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pend_br <= 1'b0;
            br_tgt  <= '0;
        end else if (flush || advance) begin
            pend_br <= 1'b0;
        end else if (branch_flag) begin
            // A newer pulse simply replaces an older captured target.
            pend_br <= 1'b1;
            br_tgt  <= branch_target;
        end
    end

    // A pulse arriving on the advancing edge itself is used directly.
    always_comb begin
        next_pc = pc + 32'd4;
        if (branch_flag) begin
            next_pc = branch_target;
        end else if (pend_br) begin
            next_pc = br_tgt;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - PC owner and instruction fetcher feeding the IF/ID register
//
// Ports:
//   clk, rst                     clock and synchronous active-low reset
//   stall[5:0]                   pipeline stall vector, bit 0 freezes this stage
//   flush, new_pc                exception redirect
//   branch_flag, branch_target   branch redirect from ID
//   ibus_req/addr/ack/rdata      instruction bus (request held until ack)
//   if_pc/if_inst/if_excepttype  presented instruction
//   stallreq_if                  high while no valid instruction is presented
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   flush,
    input  logic [InstAddrBus-1:0] new_pc,
    input  logic                   branch_flag,
    input  logic [InstAddrBus-1:0] branch_target,
    output logic                   ibus_req,
    output logic [InstAddrBus-1:0] ibus_addr,
    input  logic                   ibus_ack,
    input  logic [InstBus-1:0]     ibus_rdata,
    output logic [InstAddrBus-1:0] if_pc,
    output logic [InstBus-1:0]     if_inst,
    output logic [ExceptBus-1:0]   if_excepttype,
    output logic                   stallreq_if
);

    if_state_t              state;
    if_state_t              state_next;
    logic [InstAddrBus-1:0] pc;
    logic [InstAddrBus-1:0] next_pc;
    logic [InstAddrBus-1:0] discard_addr;
    logic [InstBus-1:0]     inst_buf;
    logic [ExceptBus-1:0]   exc_buf;
    logic                   aligned;
    logic                   advance;
    logic                   unused_stall;

    assign unused_stall = |stall[5:1];
    assign aligned      = word_aligned(pc);
    assign advance      = (state == IF_VALID) && (stall[0] == NoStop) && !flush;

    if_branch_latch u_branch_latch (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .advance       (advance),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .pc            (pc),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state        <= IF_FETCH;
            pc           <= RESET_PC;
            inst_buf     <= '0;
            exc_buf      <= '0;
            discard_addr <= '0;
        end else begin
            state <= state_next;

            if (flush) begin
                pc <= new_pc;
            end else if (advance) begin
                pc <= next_pc;
            end

            if (state == IF_FETCH && !flush) begin
                if (!aligned) begin
                    inst_buf <= '0;
                    exc_buf  <= EXC_IF_ADEL_MASK;
                end else if (ibus_ack) begin
                    inst_buf <= ibus_rdata;
                    exc_buf  <= '0;
                end
            end

            // The abandoned request must keep its original address until acked.
            if (state == IF_FETCH && flush && aligned && !ibus_ack) begin
                discard_addr <= pc;
            end
        end
    end

    always_comb begin
        state_next    = state;
        ibus_req      = 1'b0;
        ibus_addr     = pc;
        stallreq_if   = 1'b1;
        if_pc         = '0;
        if_inst       = '0;
        if_excepttype = '0;

        case (state)
            IF_FETCH: begin
                ibus_req = aligned;
                if (flush) begin
                    state_next = (aligned && !ibus_ack) ? IF_DISCARD : IF_FETCH;
                end else if (!aligned || ibus_ack) begin
                    state_next = IF_VALID;
                end
            end
            IF_VALID: begin
                stallreq_if   = 1'b0;
                if_pc         = pc;
                if_inst       = inst_buf;
                if_excepttype = exc_buf;
                if (flush || stall[0] != Stop) begin
                    state_next = IF_FETCH;
                end
            end
            IF_DISCARD: begin
                ibus_req  = 1'b1;
                ibus_addr = discard_addr;
                if (!flush && ibus_ack) begin
                    state_next = IF_FETCH;
                end
            end
            default: begin
                state_next = IF_FETCH;
            end
        endcase

        // While reset is asserted the bus and the IF/ID interface are quiet.
        if (rst == RstEnable) begin
            ibus_req      = 1'b0;
            stallreq_if   = 1'b0;
            if_pc         = '0;
            if_inst       = '0;
            if_excepttype = '0;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized self-checking bench for if_fetch
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] ADEL     = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] if_excepttype;
    logic        stallreq_if;

    int n_cmp = 0;
    int n_bad = 0;

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .ibus_req      (ibus_req),
        .ibus_addr     (ibus_addr),
        .ibus_ack      (ibus_ack),
        .ibus_rdata    (ibus_rdata),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_excepttype (if_excepttype),
        .stallreq_if   (stallreq_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4);
            1, 2:    a = 32'hBFC0_0000 + $urandom_range(0, 255);
            default: a = 32'hBFC0_0000 + ($urandom_range(0, 255) * 4);
        endcase
        return a;
    endfunction

    // Reference model: tracks whether an instruction is held, whether the
    // bus carries an abandoned request, and any remembered branch.
    logic [31:0] m_pc, m_tgt, m_inst, m_exc, m_dead_addr;
    bit          m_have, m_dead, m_pend;

    task automatic model_reset();
        m_pc = RESET_PC; m_have = 0; m_dead = 0; m_pend = 0; m_tgt = 0;
        m_inst = 0; m_exc = 0; m_dead_addr = 0;
    endtask

    function automatic bit model_req();
        return m_dead || (!m_have && m_pc[1:0] == 2'b00);
    endfunction

    task automatic model_step();
        bit fetching;
        fetching = !m_have && !m_dead;
        if (!rst) begin
            model_reset();
        end else if (flush) begin
            if (fetching && m_pc[1:0] == 2'b00 && !ibus_ack) begin
                m_dead = 1; m_dead_addr = m_pc;
            end
            m_have = 0; m_pc = new_pc; m_pend = 0;
        end else if (m_have) begin
            if (!stall[0]) begin
                m_pc = branch_flag ? branch_target : (m_pend ? m_tgt : m_pc + 32'd4);
                m_pend = 0; m_have = 0;
            end else if (branch_flag) begin
                m_pend = 1; m_tgt = branch_target;
            end
        end else begin
            if (m_dead) begin
                if (ibus_ack) m_dead = 0;
            end else if (m_pc[1:0] != 2'b00) begin
                m_have = 1; m_inst = 0; m_exc = ADEL;
            end else if (ibus_ack) begin
                m_have = 1; m_inst = ibus_rdata; m_exc = 0;
            end
            if (branch_flag) begin
                m_pend = 1; m_tgt = branch_target;
            end
        end
    endtask

    task automatic compare_outputs();
        bit r;
        r = model_req();
        if (!rst) begin
            check("rst_req", {31'd0, ibus_req}, 32'd0);
            check("rst_stallreq", {31'd0, stallreq_if}, 32'd0);
            check("rst_if_pc", if_pc, 32'd0);
            check("rst_if_inst", if_inst, 32'd0);
            check("rst_if_exc", if_excepttype, 32'd0);
        end else begin
            check("ibus_req", {31'd0, ibus_req}, {31'd0, r});
            if (r) check("ibus_addr", ibus_addr, m_dead ? m_dead_addr : m_pc);
            check("stallreq_if", {31'd0, stallreq_if}, {31'd0, !m_have});
            check("if_pc", if_pc, m_have ? m_pc : 32'd0);
            check("if_inst", if_inst, m_have ? m_inst : 32'd0);
            check("if_excepttype", if_excepttype, m_have ? m_exc : 32'd0);
        end
    endtask

    initial begin
        rst = 0; stall = 0; flush = 0; new_pc = 0; branch_flag = 0;
        branch_target = 0; ibus_ack = 0; ibus_rdata = 0;

        // Directed: reset, zero-wait first fetch, then sequential address.
        repeat (2) @(posedge clk);
        #1;
        check("reset_req", {31'd0, ibus_req}, 32'd0);
        check("reset_stallreq", {31'd0, stallreq_if}, 32'd0);
        check("reset_if_inst", if_inst, 32'd0);
        rst = 1; ibus_ack = 1; ibus_rdata = 32'h2401_0001;
        #1;
        check("first_req", {31'd0, ibus_req}, 32'd1);
        check("first_addr", ibus_addr, RESET_PC);
        @(posedge clk); #1;
        ibus_ack = 0;
        #1;
        check("first_if_pc", if_pc, RESET_PC);
        check("first_if_inst", if_inst, 32'h2401_0001);
        check("first_stallreq", {31'd0, stallreq_if}, 32'd0);
        @(posedge clk); #2;
        check("second_addr", ibus_addr, RESET_PC + 32'd4);
        check("second_req", {31'd0, ibus_req}, 32'd1);

        // Randomized run against the reference model.
        rst = 0;
        @(posedge clk);
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            #1;
            rst           = ($urandom_range(0, 199) != 0);
            stall         = 6'($urandom);
            stall[0]      = ($urandom_range(0, 9) < 3);
            flush         = ($urandom_range(0, 19) == 0);
            new_pc        = rand_addr();
            branch_flag   = ($urandom_range(0, 9) == 0);
            branch_target = rand_addr();
            ibus_ack      = model_req() && ($urandom_range(0, 1) == 1);
            ibus_rdata    = m_dead ? 32'hDEAD_BEEF : mem(m_pc);
            #1;
            compare_outputs();
            if (if_inst === 32'hDEAD_BEEF) check("discarded_data", if_inst, mem(if_pc));
            model_step();
            @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Producer side of the IF→ID interface. Owns the PC and fetches instructions over a request/acknowledge instruction bus.
- Presents if_pc, if_inst and if_excepttype to the IF/ID pipeline register.
- Honours pipeline stall and flush.
- Raises stallreq_if while a fetch is outstanding.
- Captures branch redirects from ID and detects misaligned fetch addresses.

Parameters:
- RESET_PC, 32'hBFC0_0000: PC loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- stall  in  6  pipeline stall vector; stall[0]=1 freezes the PC/fetch stage.
- flush  in  1  exception flush; redirect to new_pc.
- new_pc  in  32  exception/ERET target, valid with flush.
- branch_flag  in  1  one-cycle pulse from ID: take the branch.
- branch_target  in  32  branch destination, valid with branch_flag.
- ibus_req  out  1  instruction bus request.
- ibus_addr  out  32  fetch address.
- ibus_ack  in  1  bus acknowledge; ibus_rdata valid this cycle.
- ibus_rdata  in  32  fetched instruction word.
- if_pc  out  32  PC of the presented instruction.
- if_inst  out  32  presented instruction.
- if_excepttype  out  32  exception flags of the presented instruction.
- stallreq_if  out  1  1 = no valid instruction; controller must stall.

Behaviour:
- Reset (rst=0 at edge): pc=RESET_PC, state=FETCH, pend_br=0, buffers=0.
  - Outputs during reset: ibus_req=0, stallreq_if=0, if_pc/if_inst/if_excepttype=0.
  - Reset mid-transaction drops ibus_req immediately; an outstanding ack is ignored.
- States: FETCH, VALID, DISCARD.
- FETCH, aligned PC (pc[1:0]=0):
  - Drives ibus_req=1, ibus_addr=pc, stallreq_if=1, all if_* outputs = 0.
  - On ibus_ack: inst_buf←ibus_rdata, exc_buf←0, go to VALID.
  - Address is held stable until ack; a request is never withdrawn.
- FETCH, misaligned PC (pc[1:0]≠0):
  - Drives ibus_req=0, stallreq_if=1.
  - Next edge: inst_buf←0, exc_buf←EXC_IF_ADEL mask (32'h0000_2000), go to VALID.
- VALID:
  - Drives ibus_req=0, stallreq_if=0, if_pc=pc, if_inst=inst_buf, if_excepttype=exc_buf.
  - With stall[0]=1: hold all state.
  - With stall[0]=0 at the edge: pc←(pend_br|branch_flag ? target : pc+4), pend_br←0, go to FETCH.
- Branch capture: branch_flag in any state other than the advancing VALID edge sets pend_br=1 and br_tgt←branch_target.
  - A later branch_flag overwrites the captured target.
- Flush has top priority in every state:
  - pc←new_pc, pend_br←0.
  - FETCH with no ack this cycle (aligned) → DISCARD.
  - Otherwise (VALID; FETCH with ack; misaligned FETCH) → FETCH; same-cycle ack data is dropped.
- DISCARD:
  - ibus_req=1 with the old address held; stallreq_if=1; outputs 0.
  - On ack: data dropped, go to FETCH at the current pc.
  - Flush in DISCARD updates pc again and stays in DISCARD.
- PC arithmetic: 32-bit, pc+4 wraps modulo 2^32, no exception on wrap.
- Throughput: 2 cycles per instruction with zero-wait ack; plus N cycles for N wait states.

Decomposition:
- Add to the shared defines file:
  - EXC_IF_ADEL bit index 13.
  - State encodings IF_FETCH=2'd0, IF_VALID=2'd1, IF_DISCARD=2'd2.
  - RstEnable redefined as 1'b0 for this block.
  - Existing InstAddrBus, InstBus, ExceptBus, Stop/NoStop.
- One natural sub-module: if_branch_latch (pend_br/br_tgt capture and select of the next PC).
- Bus FSM and output mux stay in the top module.

Test Plan:
- Reset release, ack on the first request cycle, rdata=32'h2401_0001:
  - cycle 1: ibus_req=1, addr=BFC0_0000.
  - cycle 2: if_pc=BFC0_0000, if_inst=2401_0001, stallreq_if=0.
  - cycle 3: addr=BFC0_0004.
- Ack delayed 3 cycles: stallreq_if=1 for 4 cycles, ibus_addr constant, if_* outputs 0 throughout.
- In VALID, stall[0]=1 for 3 cycles: outputs unchanged, ibus_req=0. On release, next request to pc+4.
- branch_flag pulse (target BFC0_0100) while FETCH awaits ack: after ack and advance, next ibus_addr=BFC0_0100, not pc+4.
- flush with new_pc=BFC0_0380 during an outstanding request; ack 2 cycles later with rdata=DEAD_BEEF:
  - DEAD_BEEF is never presented.
  - Next ibus_addr=BFC0_0380.
- Branch to BFC0_0102:
  - No ibus_req for that address.
  - Then if_pc=BFC0_0102, if_inst=0, if_excepttype=0000_2000, stallreq_if=0.
